// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Types and widths shared by the round controller and the game-status tracker.
//   game_state_e  : tracker state encoding on the status bus
//   round_state_e : round_controller sequencer states
// ----------------------------------------------------------------------------
package game_pkg;

    localparam int unsigned RATING_WIDTH     = 8;
    localparam int unsigned GAME_STATE_WIDTH = 2;

    typedef enum logic [1:0] {
        LEVEL_GENERATING = 2'b00,
        LEVEL_RUNNING    = 2'b01,
        GAME_OVER        = 2'b10
    } game_state_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GEN      = 3'd1,
        ANNOUNCE = 3'd2,
        WAIT_RUN = 3'd3,
        RUN      = 3'd4,
        JUDGE    = 3'd5
    } round_state_e;

endpackage

// File: rtl/lfsr16.sv
// ----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11. Advances every cycle
// so the value seen at zone generation differs from round to round.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, loads SEED
//   value : current register contents
// ----------------------------------------------------------------------------
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] value
);

    logic feedback;

    // Tap 16 is bit 15, tap 14 is bit 13, and so on.
    assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of process ordering.
        if (!rst_n) begin
            value <= SEED;
        end else begin
            value <= {value[14:0], feedback};
        end
    end

endmodule

// File: rtl/round_controller.sv
// ----------------------------------------------------------------------------
// round_controller
// Sequences one game round: generates a safe zone from an LFSR, announces it,
// counts the round down on frame ticks and judges the player's position.
// Difficulty follows the rating latched at zone generation.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_game_status     : tracker state (00 generating, 01 running, 10 over)
//   i_is_game_paused  : pause level; freezes the countdown and holds pulses
//   i_current_rating  : current win streak
//   i_tick            : one-cycle frame strobe
//   i_restart         : restart request, honoured from GAME_OVER in IDLE
//   i_player_x        : player centre x
//   o_ready           : one-cycle pulse, zone generated
//   o_round_ended     : one-cycle pulse, round judged
//   o_is_win          : verdict, updated with o_round_ended and held
//   o_zone_left       : safe zone left edge
//   o_zone_width      : safe zone width
//   o_ticks_left      : remaining round ticks
// ----------------------------------------------------------------------------
module round_controller #(
    parameter int unsigned RATING_WIDTH     = game_pkg::RATING_WIDTH,
    parameter int unsigned GAME_STATE_WIDTH = game_pkg::GAME_STATE_WIDTH,
    parameter int unsigned POS_WIDTH        = 10,
    parameter int unsigned SCREEN_W         = 640,
    parameter int unsigned BASE_ZONE        = 200,
    parameter int unsigned ZONE_STEP        = 8,
    parameter int unsigned MIN_ZONE         = 32,
    parameter int unsigned BASE_TICKS       = 180,
    parameter int unsigned MIN_TICKS        = 30,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [GAME_STATE_WIDTH-1:0] i_game_status,
    input  logic                        i_is_game_paused,
    input  logic [RATING_WIDTH-1:0]     i_current_rating,
    input  logic                        i_tick,
    input  logic                        i_restart,
    input  logic [POS_WIDTH-1:0]        i_player_x,
    output logic                        o_ready,
    output logic                        o_round_ended,
    output logic                        o_is_win,
    output logic [POS_WIDTH-1:0]        o_zone_left,
    output logic [POS_WIDTH-1:0]        o_zone_width,
    output logic [7:0]                  o_ticks_left
);

    import game_pkg::*;

    localparam int unsigned CALC_W = RATING_WIDTH + POS_WIDTH + 1;

    localparam logic [GAME_STATE_WIDTH-1:0] STATUS_GEN  = GAME_STATE_WIDTH'(LEVEL_GENERATING);
    localparam logic [GAME_STATE_WIDTH-1:0] STATUS_RUN  = GAME_STATE_WIDTH'(LEVEL_RUNNING);
    localparam logic [GAME_STATE_WIDTH-1:0] STATUS_OVER = GAME_STATE_WIDTH'(GAME_OVER);

    round_state_e state, state_next;

    logic [15:0]          lfsr_value;
    logic [CALC_W-1:0]    shrink, zone_raw, zone_calc;
    logic [15:0]          ticks_raw, ticks_calc;
    logic [POS_WIDTH-1:0] zone_w_now, max_left, lfsr_pos, left_calc;
    logic [POS_WIDTH:0]   px_ext, left_ext, right_ext;
    logic                 win_now;
    logic                 abort;
    logic                 ready_next, ended_next, load_zone, tick_dec;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr_value)
    );

    // Difficulty: wide enough that rating*ZONE_STEP never wraps, so large
    // ratings saturate to the floor instead of producing a huge zone.
    always_comb begin
        shrink    = CALC_W'(i_current_rating) * CALC_W'(ZONE_STEP);
        zone_raw  = (shrink >= CALC_W'(BASE_ZONE)) ? '0 : CALC_W'(BASE_ZONE) - shrink;
        zone_calc = (zone_raw < CALC_W'(MIN_ZONE)) ? CALC_W'(MIN_ZONE) : zone_raw;

        ticks_raw  = (16'(i_current_rating) >= 16'(BASE_TICKS)) ?
                     16'd0 : 16'(BASE_TICKS) - 16'(i_current_rating);
        ticks_calc = (ticks_raw < 16'(MIN_TICKS)) ? 16'(MIN_TICKS) : ticks_raw;

        zone_w_now = POS_WIDTH'(zone_calc);
        max_left   = POS_WIDTH'(SCREEN_W) - zone_w_now;
        lfsr_pos   = POS_WIDTH'(lfsr_value);
        left_calc  = (lfsr_pos > max_left) ? max_left : lfsr_pos;
    end

    // Verdict uses one extra bit so left+width == SCREEN_W cannot wrap.
    always_comb begin
        px_ext    = {1'b0, i_player_x};
        left_ext  = {1'b0, o_zone_left};
        right_ext = left_ext + {1'b0, o_zone_width};
        win_now   = (px_ext >= left_ext) && (px_ext < right_ext);
    end

    assign abort = (i_game_status == STATUS_OVER);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        ready_next = 1'b0;
        ended_next = 1'b0;
        load_zone  = 1'b0;
        tick_dec   = 1'b0;

        unique case (state)
            IDLE: begin
                if ((i_game_status == STATUS_GEN && !i_is_game_paused) ||
                    (abort && i_restart)) begin
                    state_next = GEN;
                end
            end
            GEN: begin
                load_zone  = 1'b1;
                state_next = abort ? IDLE : ANNOUNCE;
            end
            ANNOUNCE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (!i_is_game_paused) begin
                    ready_next = 1'b1;
                    state_next = WAIT_RUN;
                end
            end
            WAIT_RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (i_game_status == STATUS_RUN) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (i_tick && !i_is_game_paused) begin
                    tick_dec = (o_ticks_left != 8'd0);
                    // Last tick consumed: the count reaches zero on this edge.
                    if (o_ticks_left <= 8'd1) begin
                        state_next = JUDGE;
                    end
                end
            end
            JUDGE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (!i_is_game_paused) begin
                    ended_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pulses are registered, so they appear in the cycle after the state
    // that decided them (ANNOUNCE / JUDGE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ready       <= 1'b0;
            o_round_ended <= 1'b0;
            o_is_win      <= 1'b0;
            o_zone_left   <= '0;
            o_zone_width  <= POS_WIDTH'(BASE_ZONE);
            o_ticks_left  <= 8'd0;
        end else begin
            o_ready       <= ready_next;
            o_round_ended <= ended_next;
            if (ended_next) begin
                o_is_win <= win_now;
            end
            if (load_zone) begin
                o_zone_width <= zone_w_now;
                o_zone_left  <= left_calc;
                o_ticks_left <= 8'(ticks_calc);
            end else if (tick_dec) begin
                o_ticks_left <= o_ticks_left - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// ----------------------------------------------------------------------------
// tb_round_controller
// Directed stimulus for round_controller. The stimulus process pushes the
// expected zone/verdict for each pulse into queues; a negedge monitor pops and
// compares whenever o_ready or o_round_ended is seen.
// ----------------------------------------------------------------------------
module tb_round_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] game_status = 2'b00;
    logic       is_paused = 1'b0;
    logic [7:0] rating = 8'd0;
    logic       tick = 1'b0;
    logic       restart = 1'b0;
    logic [9:0] player_x = 10'd0;

    logic       o_ready, o_round_ended, o_is_win;
    logic [9:0] o_zone_left, o_zone_width;
    logic [7:0] o_ticks_left;

    round_controller dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_game_status    (game_status),
        .i_is_game_paused (is_paused),
        .i_current_rating (rating),
        .i_tick           (tick),
        .i_restart        (restart),
        .i_player_x       (player_x),
        .o_ready          (o_ready),
        .o_round_ended    (o_round_ended),
        .o_is_win         (o_is_win),
        .o_zone_left      (o_zone_left),
        .o_zone_width     (o_zone_width),
        .o_ticks_left     (o_ticks_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit check_left;
        int left;
        int width;
        int ticks;
    } ready_exp_t;

    ready_exp_t ready_q[$];
    bit         verdict_q[$];

    int checks = 0;
    int errors = 0;
    int ready_count = 0;
    int ended_count = 0;

    task automatic check(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] lfsr_step(logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic push_ready(bit chk_left, int left, int width, int ticks);
        ready_exp_t e;
        e.check_left = chk_left;
        e.left       = left;
        e.width      = width;
        e.ticks      = ticks;
        ready_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds tick high for n consecutive sampling edges.
    task automatic send_ticks(int n);
        @(posedge clk);
        #1 tick = 1'b1;
        repeat (n) @(posedge clk);
        #1 tick = 1'b0;
    endtask

    // Counts negedges until o_ready is seen (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_ready && n < 40);
    endtask

    task automatic wait_ended(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_round_ended && n < 40);
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_ready"},  int'(o_ready), 0);
        check({tag, "_ended"},  int'(o_round_ended), 0);
        check({tag, "_win"},    int'(o_is_win), 0);
        check({tag, "_left"},   int'(o_zone_left), 0);
        check({tag, "_width"},  int'(o_zone_width), 200);
        check({tag, "_ticks"},  int'(o_ticks_left), 0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && (o_ready || o_round_ended)) begin
            check("pulse_while_paused", int'(is_paused), 0);
            check("pulses_exclusive", int'(o_ready & o_round_ended), 0);
        end
        if (rst_n && o_ready) begin : mon_ready
            ready_exp_t e;
            ready_count++;
            if (ready_q.size() == 0) begin
                check("unexpected_ready", int'(o_ready), 0);
            end else begin
                e = ready_q.pop_front();
                check("zone_width", int'(o_zone_width), e.width);
                check("ticks_init", int'(o_ticks_left), e.ticks);
                check("zone_fits_screen",
                      (int'(o_zone_left) + int'(o_zone_width) <= 640) ? 1 : 0, 1);
                if (e.check_left) begin
                    check("zone_left", int'(o_zone_left), e.left);
                end
            end
        end
        if (rst_n && o_round_ended) begin
            ended_count++;
            if (verdict_q.size() == 0) begin
                check("unexpected_round_end", int'(o_round_ended), 0);
            end else begin
                check("verdict", int'(o_is_win), int'(verdict_q.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int saved_ready, saved_ended;
        logic [15:0] s1;
        int first_left;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");

        // GEN sees the seed stepped once (the IDLE->GEN edge also steps it).
        s1 = lfsr_step(16'hACE1);
        first_left = (int'(s1[9:0]) > 440) ? 440 : int'(s1[9:0]);

        // ---------------- round 1: rating 0, upper win boundary ----------------
        // The first edge leaves IDLE; the pulse is 2 cycles later, which the
        // negedge counter sees as the third sample.
        push_ready(1'b1, first_left, 200, 180);
        rst_n = 1'b1;
        wait_ready(n);
        check("ready_latency_reset", n, 3);
        game_status = 2'b01;
        send_ticks(179);
        check("ticks_before_last_r1", int'(o_ticks_left), 1);
        player_x = 10'(first_left + 200 - 1);
        verdict_q.push_back(1'b1);
        send_ticks(1);
        wait_ended(n);
        check("ended_latency", n, 2);

        // ---------------- round 2: rating 25, just outside ----------------
        @(negedge clk);
        rating      = 8'd25;
        game_status = 2'b00;
        push_ready(1'b0, 0, 32, 155);
        wait_ready(n);
        check("ready_latency_r2", n, 3);
        rating      = 8'd0;          // must not affect the latched round
        game_status = 2'b01;
        send_ticks(154);
        check("ticks_before_last_r2", int'(o_ticks_left), 1);
        player_x = o_zone_left + o_zone_width;
        verdict_q.push_back(1'b0);
        send_ticks(1);
        wait_ended(n);
        check("ended_seen_r2", int'(o_round_ended), 1);

        // ---------------- round 3: rating 255, pause in RUN and JUDGE ----------------
        @(negedge clk);
        rating      = 8'd255;
        game_status = 2'b00;
        push_ready(1'b0, 0, 32, 30);
        wait_ready(n);
        check("ready_latency_r3", n, 3);
        game_status = 2'b01;
        send_ticks(10);
        check("ticks_after_10", int'(o_ticks_left), 20);
        is_paused = 1'b1;
        send_ticks(50);
        check("ticks_frozen_paused", int'(o_ticks_left), 20);
        is_paused = 1'b0;
        send_ticks(19);
        check("ticks_before_last_r3", int'(o_ticks_left), 1);
        player_x = o_zone_left;
        verdict_q.push_back(1'b1);
        send_ticks(1);
        is_paused = 1'b1;
        saved_ended = ended_count;
        repeat (20) step();
        check("no_end_while_paused", ended_count, saved_ended);
        is_paused = 1'b0;
        wait_ended(n);
        check("end_after_release", int'(o_round_ended), 1);
        repeat (10) step();
        check("single_end_pulse", ended_count, saved_ended + 1);

        // ---------------- GAME_OVER in IDLE, then restart ----------------
        game_status = 2'b10;
        saved_ready = ready_count;
        repeat (20) step();
        check("idle_game_over_quiet", ready_count, saved_ready);
        @(negedge clk);
        restart   = 1'b1;
        is_paused = 1'b1;
        rating    = 8'd3;
        push_ready(1'b0, 0, 176, 177);
        @(posedge clk);
        #1;
        restart     = 1'b0;
        is_paused   = 1'b0;
        game_status = 2'b00;
        wait_ready(n);
        check("ready_latency_restart", n, 3);

        // ---------------- GAME_OVER forced during RUN ----------------
        game_status = 2'b01;
        send_ticks(5);
        check("ticks_after_5", int'(o_ticks_left), 172);
        game_status = 2'b10;
        saved_ready = ready_count;
        saved_ended = ended_count;
        repeat (20) step();
        check("abort_no_ready", ready_count, saved_ready);
        check("abort_no_end", ended_count, saved_ended);
        @(negedge clk);
        rating      = 8'd10;
        game_status = 2'b00;
        push_ready(1'b0, 0, 120, 170);
        wait_ready(n);
        check("ready_latency_after_abort", n, 3);

        // ---------------- asynchronous reset during RUN ----------------
        game_status = 2'b01;
        send_ticks(3);
        check("ticks_after_3", int'(o_ticks_left), 167);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (5) step();
        check("ready_queue_drained", ready_q.size(), 0);
        check("verdict_queue_drained", verdict_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_controller.md
# round_controller

Round sequencer that sits upstream of the game-status tracker and drives its round-handshake inputs. It produces each level's safe zone with a pseudo-random generator, announces completion, times the round, and judges the player's position at timeout. Difficulty comes from the current rating: the zone narrows and the round shortens as the rating grows.

## Interface
Parameters:
- RATING_WIDTH, 8, rating bus width.
- GAME_STATE_WIDTH, 2, game-state bus width.
- POS_WIDTH, 10, horizontal position width.
- SCREEN_W, 640, playfield width in pixels.
- BASE_ZONE, 200, zone width at rating 0.
- ZONE_STEP, 8, zone shrink per rating point.
- MIN_ZONE, 32, zone width floor.
- BASE_TICKS, 180, round length at rating 0, in frame ticks.
- MIN_TICKS, 30, round length floor.
- LFSR_SEED, 16'hACE1, non-zero LFSR reset seed.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- i_game_status, in, GAME_STATE_WIDTH, tracker state: 00 LEVEL_GENERATING, 01 LEVEL_RUNNING, 10 GAME_OVER.
- i_is_game_paused, in, 1, pause level.
- i_current_rating, in, RATING_WIDTH, current win streak.
- i_tick, in, 1, one-cycle frame strobe.
- i_restart, in, 1, one-cycle restart request, honoured only when the tracker reports GAME_OVER.
- i_player_x, in, POS_WIDTH, player centre x.
- o_ready, out, 1, one-cycle pulse: zone generated.
- o_round_ended, out, 1, one-cycle pulse: round judged.
- o_is_win, out, 1, verdict, valid with o_round_ended and held until the next verdict.
- o_zone_left, out, POS_WIDTH, safe zone left edge.
- o_zone_width, out, POS_WIDTH, safe zone width.
- o_ticks_left, out, 8, remaining round ticks.

## Operation
- FSM states: IDLE, GEN, ANNOUNCE, WAIT_RUN, RUN, JUDGE.
- **IDLE.** Go to GEN when i_game_status == 00 and not paused.
  - Also go to GEN when i_game_status == 10 and i_restart is high, even if paused.
- **GEN.** One cycle, with the LFSR stepped once.
  - Latch w = max(MIN_ZONE, BASE_ZONE − rating·ZONE_STEP). Compute it in a width of RATING_WIDTH+POS_WIDTH+1 bits, with saturating subtraction.
  - Latch left = min(lfsr[POS_WIDTH-1:0], SCREEN_W − w).
  - Latch ticks = max(MIN_TICKS, BASE_TICKS − rating), saturating.
- **ANNOUNCE.** Wait while paused. When not paused, assert o_ready for one cycle and go to WAIT_RUN.
- **WAIT_RUN.** Go to RUN when i_game_status == 01.
- **RUN.** Each i_tick while not paused decrements o_ticks_left.
  - When the count reaches 0, go to JUDGE.
  - i_tick is ignored while paused.
- **JUDGE.** Wait while paused. When not paused:
  - o_is_win = (i_player_x ≥ left) && (i_player_x < left + w), sampled in that cycle.
  - Assert o_round_ended for one cycle, then go to IDLE.
- o_ready and o_round_ended never assert in the same cycle, and never while paused. The tracker discards both while paused.
- The LFSR is 16-bit Fibonacci, taps 16,14,13,11. It free-runs every cycle so that seeds differ between rounds.
- The rating is sampled only in GEN. A rating change mid-round has no effect.
- If i_game_status becomes 10 outside IDLE, return to IDLE next cycle with no pulse.

## Timing
- Reset values:
  - FSM = IDLE.
  - o_ready = o_round_ended = o_is_win = 0.
  - o_zone_left = 0, o_zone_width = BASE_ZONE, o_ticks_left = 0.
  - LFSR = LFSR_SEED.
- Latency from IDLE with status 00 (unpaused) to the o_ready pulse is 2 cycles: IDLE→GEN→ANNOUNCE.
- The round lasts exactly ticks unpaused i_tick strobes. o_round_ended rises 1 cycle after the RUN→JUDGE transition if not paused.
- All outputs are registered.
- An asynchronous reset mid-round aborts the round with no pulses.

## Structure
- Shared package game_pkg holds:
  - the game_state enum (00/01/10);
  - RATING_WIDTH and GAME_STATE_WIDTH;
  - the round_state enum.
- The game-status tracker imports the same enum.
- Sub-module: lfsr16 (clk, rst_n, seed parameter, 16-bit output).

## Test plan
- Reset, rating 0, status 00: o_ready after 2 cycles; o_zone_width = 200; o_zone_left ≤ 440; ticks = 180.
- Rating 25: width saturates to 32 and ticks = 155. Rating 255: width 32, ticks 30, no wrap.
- Player at left+width−1 when ticks hit 0: o_round_ended pulse with o_is_win = 1. Player at left+width: o_is_win = 0.
- Pause held over 50 ticks mid-RUN: o_ticks_left frozen. Pause held during JUDGE: no pulse until release, then exactly one pulse.
- Status 10 in IDLE: no activity until i_restart, then GEN and o_ready after 2 cycles. Status forced to 10 during RUN: IDLE next cycle, no pulses.
- Assert rst_n low during RUN: all outputs return to reset values asynchronously.
